// File: rtl/md_pkg.sv
// Shared encodings, state type and latency defaults for the multiply/divide scheduler.
// The multiply-accumulate ops are only scheduled when MD_SCHED_MACC_EN is defined.
package md_pkg;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle RUN.
  function automatic logic is_run_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) || is_div(op);
`ifdef MD_SCHED_MACC_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit result for the captured op; wr drops when the result must not
// be committed (divide by zero, or an op with no arithmetic result).
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        wr
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        acc;
  logic [31:0]        b_safe;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  // Low 64 bits of the product of the extended operands equal the true signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign acc    = {hi, lo};

  // The divider never sees zero; the zero-divisor result is discarded via wr.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign q_s    = $signed(a) / $signed(b_safe);
  assign r_s    = $signed(a) % $signed(b_safe);
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;

  // NOTE: every output gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    res = acc;
    wr  = 1'b1;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        res = {r_s, q_s};
        wr  = (b != 32'd0);
      end
      OP_DIVU: begin
        res = {r_u, q_u};
        wr  = (b != 32'd0);
      end
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_MSUBU: res = acc - prod_u;
      default:  wr  = 1'b0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: IDLE/RUN FSM, busy down-counter and the HI/LO registers.
// Define MD_SCHED_MACC_EN to schedule MADD/MADDU/MSUB/MSUBU; otherwise they act as NOP.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        md_in_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = ($clog2(LAT_MAX + 1) < 4) ? 4 : $clog2(LAT_MAX + 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [3:0]         op_q;
  logic [31:0]        a_q, b_q;
  logic [31:0]        hi_nxt, lo_nxt;
  logic               cap;
  logic [63:0]        res;
  logic               res_wr;

  md_arith u_arith (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .hi  (hi),
    .lo  (lo),
    .res (res),
    .wr  (res_wr)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          if (is_run_op(md_op)) begin
            state_nxt = RUN;
            cnt_nxt   = is_div(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            cap       = 1'b1;
          end else if (md_op == OP_MTHI) begin
            hi_nxt = src_a;
          end else if (md_op == OP_MTLO) begin
            lo_nxt = src_a;
          end
        end
      end
      RUN: begin
        // A kill wins over completion so a flushed op never commits.
        if (flush) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (res_wr) {hi_nxt, lo_nxt} = res;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the captured operands are reset too, so nothing stale survives a mid-RUN reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      if (cap) begin
        op_q <= md_op;
        a_q  <= src_a;
        b_q  <= src_b;
      end
    end
  end

  assign busy     = (state == RUN);
  assign md_stall = md_in_d & (busy | start);

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: a table of ops with hand-computed HI/LO and busy length,
// followed by hand-written stall, flush and reset sequences.
module tb_md_sched;
  import md_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        md_in_d;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .md_in_d  (md_in_d),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge, scramble the live operands during RUN, then measure
  // the busy length and check HI/LO in the cycle busy falls.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    n = 0;
    while (busy && n < 40) begin
      src_a = $urandom;
      src_b = $urandom;
      n++;
      @(negedge clk);
    end
    check({name, " busy_len"}, 64'(n), 64'(lat));
    check({name, " hi"}, 64'(hi), 64'(ehi));
    check({name, " lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int n;
    int stall_seen;

    vecs[0]  = '{"mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{"multu",     OP_MULTU, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{"div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_zero", OP_DIVU,  32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{"divu",      OP_DIVU,  32'hFFFFFFF9, 32'd2,        10, 32'h00000001, 32'h7FFFFFFC};
    vecs[5]  = '{"div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[6]  = '{"mthi",      OP_MTHI,  32'd0,        32'd9,        0,  32'h00000000, 32'hFFFFFFFD};
    vecs[7]  = '{"mtlo",      OP_MTLO,  32'hFFFFFFFF, 32'd9,        0,  32'h00000000, 32'hFFFFFFFF};
`ifdef MD_SCHED_MACC_EN
    vecs[8]  = '{"maddu",     OP_MADDU, 32'd1,        32'd1,        5,  32'h00000001, 32'h00000000};
    vecs[9]  = '{"msub",      OP_MSUB,  32'd1,        32'd1,        5,  32'h00000000, 32'hFFFFFFFF};
    vecs[10] = '{"madd_neg",  OP_MADD,  32'hFFFFFFFF, 32'd2,        5,  32'h00000000, 32'hFFFFFFFD};
    vecs[11] = '{"msubu",     OP_MSUBU, 32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFE, 32'hFFFFFFFF};
`else
    vecs[8]  = '{"maddu",     OP_MADDU, 32'd1,        32'd1,        0,  32'h00000000, 32'hFFFFFFFF};
    vecs[9]  = '{"msub",      OP_MSUB,  32'd1,        32'd1,        0,  32'h00000000, 32'hFFFFFFFF};
    vecs[10] = '{"madd_neg",  OP_MADD,  32'hFFFFFFFF, 32'd2,        0,  32'h00000000, 32'hFFFFFFFF};
    vecs[11] = '{"msubu",     OP_MSUBU, 32'hFFFFFFFF, 32'd2,        0,  32'h00000000, 32'hFFFFFFFF};
`endif
    vecs[12] = '{"mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    vecs[13] = '{"nop",       OP_NOP,   32'h12345678, 32'd1,        0,  32'h40000000, 32'h00000000};

    rst_n   = 1'b0;
    start   = 1'b0;
    md_op   = 4'd0;
    src_a   = '0;
    src_b   = '0;
    flush   = 1'b0;
    md_in_d = 1'b0;
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst stall", 64'(md_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].ehi, vecs[i].elo);

    // MTHI writes the next cycle without entering RUN.
    @(negedge clk);
    start = 1'b1; md_op = OP_MTHI; src_a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    check("mthi hi", 64'(hi), 64'h12345678);
    check("mthi busy", 64'(busy), 64'd0);

    // Stall with md_in_d high: start cycle plus the five RUN cycles.
    @(negedge clk);
    md_in_d = 1'b1; start = 1'b1; md_op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
    #1 check("stall start", 64'(md_stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (md_stall && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("stall run_len", 64'(n), 64'd5);
    check("stall mult lo", 64'(lo), 64'd12);
    check("stall mult hi", 64'(hi), 64'd0);

    // Stall with md_in_d low: never asserted.
    md_in_d = 1'b0;
    stall_seen = 0;
    start = 1'b1; md_op = OP_MULT; src_a = 32'd2; src_b = 32'd2;
    #1 if (md_stall) stall_seen++;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      if (md_stall) stall_seen++;
      n++;
      @(negedge clk);
    end
    check("nostall count", 64'(stall_seen), 64'd0);
    check("nostall lo", 64'(lo), 64'd4);

    // Flush on RUN cycle 3 of a DIV: back to IDLE, HI/LO untouched.
    start = 1'b1; md_op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush run3 busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi", 64'(hi), 64'd0);
    check("flush lo", 64'(lo), 64'd4);
    repeat (12) @(negedge clk);
    check("flush late lo", 64'(lo), 64'd4);

    // Flush together with start in IDLE suppresses both RUN ops and MTxx writes.
    start = 1'b1; flush = 1'b1; md_op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    check("flush_start busy", 64'(busy), 64'd0);
    md_op = OP_MTHI; src_a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_mthi hi", 64'(hi), 64'd0);

    // Reset on RUN cycle 2 clears state immediately.
    start = 1'b1; md_op = OP_MULT; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_run busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_run busy", 64'(busy), 64'd0);
    check("rst_run hi", 64'(hi), 64'd0);
    check("rst_run lo", 64'(lo), 64'd0);

    // First start is accepted at the first rising edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; md_op = OP_MULT; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("post_rst busy_len", 64'(n), 64'd5);
    check("post_rst lo", 64'(lo), 64'd30);
    check("post_rst hi", 64'(hi), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
